// File: rtl/scan_fault_pkg.sv
// Shared definitions for the fault-injectable scan chain: default chain
// length and the stuck-at value encoding.
// Fault injection is compiled in only when SCAN_FAULT_INJECT_EN is defined.
package scan_fault_pkg;

    localparam int DEFAULT_CHAIN_LEN = 8;

    typedef enum logic {
        SA0 = 1'b0,
        SA1 = 1'b1
    } sa_value_e;

    function automatic sa_value_e to_sa(input logic v);
        return v ? SA1 : SA0;
    endfunction

endpackage

// File: rtl/scan_cell.sv
// Single scan cell: async-reset flop with shift/hold and an output force mux
// used to model a stuck-at fault on this cell.
module scan_cell
    import scan_fault_pkg::*;
(
    input  logic      sclk,
    input  logic      rst_n,
    input  logic      se,
    input  logic      d,
    input  logic      force_en,
    input  sa_value_e force_val,
    output logic      eff
);

    logic q;

    // Shift in d when se is high, otherwise hold; reset clears asynchronously
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (se) begin
            q <= d;
        end
    end

    // The flop keeps capturing under a fault; only what it presents is forced
    always_comb begin
        eff = q;
        if (force_en) begin
            eff = logic'(force_val);
        end
    end

endmodule

// File: rtl/dut_scan_faulty.sv
// Scan chain of CHAIN_LEN cells with optional stuck-at fault injection on one
// selectable cell. Define SCAN_FAULT_INJECT_EN to enable injection; without
// it the fault ports are present but ignored and the chain is golden.
module dut_scan_faulty
    import scan_fault_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int IDX_W     = $clog2(CHAIN_LEN)
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             se,
    input  logic             si,
    output logic             so,
    input  logic             fault_en,
    input  logic [IDX_W-1:0] fault_idx,
    input  logic             fault_sa_value
);

    logic [CHAIN_LEN-1:0] eff;
    logic [CHAIN_LEN-1:0] chain_in;
    logic [CHAIN_LEN-1:0] fault_hit;
    sa_value_e            sa_val;

    // Each cell takes the effective (possibly forced) output of its neighbour
    assign chain_in = {eff[CHAIN_LEN-2:0], si};

`ifdef SCAN_FAULT_INJECT_EN
    // One-hot fault decode; indices beyond the chain never match any cell
    always_comb begin
        fault_hit = '0;
        for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
            if (fault_en && (fault_idx == IDX_W'(i))) begin
                fault_hit[i] = 1'b1;
            end
        end
    end

    assign sa_val = to_sa(fault_sa_value);
`else
    logic unused_fault;

    assign fault_hit    = '0;
    assign sa_val       = SA0;
    assign unused_fault = ^{fault_en, fault_idx, fault_sa_value};
`endif

    for (genvar g = 0; g < CHAIN_LEN; g++) begin : g_cell
        scan_cell u_cell (
            .sclk      (sclk),
            .rst_n     (rst_n),
            .se        (se),
            .d         (chain_in[g]),
            .force_en  (fault_hit[g]),
            .force_val (sa_val),
            .eff       (eff[g])
        );
    end

    assign so = eff[CHAIN_LEN-1];

endmodule

// File: tb/tb_dut_scan_faulty.sv
// Self-checking bench for dut_scan_faulty: an 8-cell and a 12-cell chain
// driven side by side, checked against an array model of the chain and,
// for fault-free runs, a plain delay-line history of scan-in bits.
module tb_dut_scan_faulty;

    logic       sclk;
    logic       rst_n;
    logic       se;
    logic       si;
    logic       so8;
    logic       so12;
    logic       f8_en;
    logic [2:0] f8_idx;
    logic       f8_sa;
    logic       f12_en;
    logic [3:0] f12_idx;
    logic       f12_sa;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: [0] = 8-cell chain, [1] = 12-cell chain
    bit cell_m [2][16];
    int lens [2] = '{8, 12};
    bit hist [$];
    bit hist_on = 0;

    dut_scan_faulty #(.CHAIN_LEN(8)) dut8 (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .se             (se),
        .si             (si),
        .so             (so8),
        .fault_en       (f8_en),
        .fault_idx      (f8_idx),
        .fault_sa_value (f8_sa)
    );

    dut_scan_faulty #(.CHAIN_LEN(12)) dut12 (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .se             (se),
        .si             (si),
        .so             (so12),
        .fault_en       (f12_en),
        .fault_idx      (f12_idx),
        .fault_sa_value (f12_sa)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    function automatic bit m_eff(int d, int i);
        bit act;
        act = 1'b0;
`ifdef SCAN_FAULT_INJECT_EN
        if (d == 0) act = f8_en  && (int'(f8_idx)  == i);
        else        act = f12_en && (int'(f12_idx) == i);
`endif
        if (act) return (d == 0) ? f8_sa : f12_sa;
        return cell_m[d][i];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) cell_m[d][i] = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit nv [16];
        if (rst_n !== 1'b1 || se !== 1'b1) return;
        for (int d = 0; d < 2; d++) begin
            nv[0] = si;
            for (int i = 1; i < lens[d]; i++) nv[i] = m_eff(d, i - 1);
            for (int i = 0; i < lens[d]; i++) cell_m[d][i] = nv[i];
        end
        hist.push_front(si);
    endtask

    task automatic check(string tag);
        bit e8, e12, eh;
        e8  = m_eff(0, 7);
        e12 = m_eff(1, 11);
        n_assert++;
        assert (so8 === e8) else begin
            n_fail++;
            $error("FAIL %s dut8: so=%b expected %b", tag, so8, e8);
        end
        n_assert++;
        assert (so12 === e12) else begin
            n_fail++;
            $error("FAIL %s dut12: so=%b expected %b", tag, so12, e12);
        end
        if (hist_on) begin
            eh = (hist.size() >= 12) ? hist[11] : 1'b0;
            n_assert++;
            assert (so12 === eh) else begin
                n_fail++;
                $error("FAIL %s dut12_delay: so=%b expected %b", tag, so12, eh);
            end
        end
    endtask

    task automatic edge_chk(string tag);
        @(posedge sclk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic apply_reset(string tag);
        rst_n = 1'b0;
        model_clear();
        #1;
        check(tag);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_f8(input logic en, input logic [2:0] idx, input logic sa);
        f8_en = en; f8_idx = idx; f8_sa = sa;
    endtask

    task automatic set_f12(input logic en, input logic [3:0] idx, input logic sa);
        f12_en = en; f12_idx = idx; f12_sa = sa;
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  b;
        bit          exp_c;

        rst_n = 1'b0; se = 1'b0; si = 1'b0;
        set_f8(1'b0, 3'd0, 1'b0);
        set_f12(1'b0, 4'd0, 1'b0);
        model_clear();
        #2;
        check("reset_initial");
        n_assert++;
        assert (so8 === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_so8_zero: so=%b expected 0", so8);
        end
        #1 rst_n = 1'b1;

        // golden: FF then 00, MSB first
        hist_on = 1'b1;
        pat = 16'hFF00;
        se = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            si = pat[k];
            edge_chk("golden");
            exp_c = ((16 - k) >= 8) && ((16 - k) <= 15);
            n_assert++;
            assert (so8 === exp_c) else begin
                n_fail++;
                $error("FAIL golden_edge%0d: so=%b expected %b", 16 - k, so8, exp_c);
            end
        end

        // SA0 on cell 3 of the 8-cell chain, same patterns
        apply_reset("reset_sa0");
        set_f8(1'b1, 3'd3, 1'b0);
        #1 check("sa0_apply");
        for (int k = 15; k >= 0; k--) begin
            si = pat[k];
            edge_chk("sa0_idx3");
        end

        // SA1 on cell 5, shift zeros
        set_f8(1'b1, 3'd5, 1'b1);
        apply_reset("reset_sa1_5");
        for (int k = 7; k >= 0; k--) begin
            si = 1'b0;
            edge_chk("sa1_idx5");
        end

        // SA1 on last cell, random data, checked in and out of reset
        set_f8(1'b1, 3'd7, 1'b1);
        apply_reset("reset_sa1_7");
        check("sa1_7_release");
        for (int k = 0; k < 8; k++) begin
            si = 1'($urandom_range(0, 1));
            edge_chk("sa1_idx7");
        end

        // out-of-range index on the 12-cell chain must be golden
        set_f8(1'b0, 3'd0, 1'b0);
        apply_reset("reset_oor");
        set_f12(1'b1, 4'($urandom_range(12, 15)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 20; k++) begin
            si = 1'($urandom_range(0, 1));
            edge_chk("oor_idx");
            if (k == 10) set_f12(1'b1, 4'($urandom_range(12, 15)), ~f12_sa);
        end
        set_f12(1'b0, 4'd0, 1'b0);

        // load A5, hold three edges, resume, then reset mid-shift
        apply_reset("reset_hold");
        b = 8'hA5;
        for (int k = 7; k >= 0; k--) begin
            si = b[k];
            edge_chk("load_a5");
        end
        se = 1'b0;
        for (int k = 0; k < 3; k++) begin
            si = ~si;
            edge_chk("hold");
        end
        se = 1'b1;
        si = 1'b1;
        edge_chk("resume");
        edge_chk("resume");
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midshift_reset");
        n_assert++;
        assert (so8 === 1'b0 && so12 === 1'b0) else begin
            n_fail++;
            $error("FAIL midshift_reset_zero: so8=%b so12=%b expected 0 0", so8, so12);
        end
        edge_chk("in_reset_edge");
        rst_n = 1'b1;
        hist_on = 1'b0;

        // random traffic with fault controls changing mid-shift
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_f8(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)));
                set_f12(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
                #1;
                check("rand_fault_change");
            end
            if ($urandom_range(0, 39) == 0) begin
                apply_reset("rand_reset");
            end
            se = ($urandom_range(0, 3) != 0);
            si = 1'($urandom_range(0, 1));
            edge_chk("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
